// File: rtl/constrained_random_arb_pkg.sv
// ============================================================================
// Module      : constrained_random_arb_pkg
// Description : Shared types, LFSR polynomial and helper functions for the
//               constrained random arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package constrained_random_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_GRANT = 2'd2
    } state_t;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] c_lfsr_poly = 32'h80200003;

    // Smallest 2^k-1 that covers d: smear the top set bit downwards
    function automatic logic [31:0] mask_of(input logic [31:0] d);
        logic [31:0] m;
        m = d;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return m;
    endfunction

    // Returns {found, index}: first set request at or after ptr, wrapping at n
    function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic       found;
        logic [3:0] idx;
        logic [3:0] jj;
        int         j;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!found && (i < n)) begin
                j = int'(ptr) + i;
                if (j >= n) j = j - n;
                jj = 4'(j);
                if (req[jj]) begin
                    found = 1'b1;
                    idx   = jj;
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cr_lfsr32.sv
// ============================================================================
// Module      : cr_lfsr32
// Description : 32-bit Galois LFSR with step and synchronous load; a zero
//               seed or load value is replaced by 1 to avoid lock-up.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cr_lfsr32
    import constrained_random_arb_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_step,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic [31:0] o_state
);

    localparam logic [31:0] c_seed_rst = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_seed_rst;
        end else if (i_load) begin
            r_state <= (i_load_val == 32'h0) ? 32'h1 : i_load_val;
        end else if (i_step) begin
            r_state <= {1'b0, r_state[31:1]} ^ (r_state[0] ? c_lfsr_poly : 32'h0);
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/constrained_random_arbiter.sv
// ============================================================================
// Module      : constrained_random_arbiter
// Description : Round-robin shared random source; draws uniform values in
//               per-requester [min,max] by rejection sampling on an LFSR.
//               Optional macro CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN adds
//               SEED_LD/SEED_IN for run-time reseeding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module constrained_random_arbiter
    import constrained_random_arb_pkg::*;
#(
    parameter int          NREQ      = 4,
    parameter int          WIDTH     = 8,
    parameter int          MAX_TRIES = 8,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
    input  logic                  SEED_LD,
    input  logic [31:0]           SEED_IN,
`endif
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] REQ_MIN,
    input  logic [NREQ*WIDTH-1:0] REQ_MAX,
    output logic [NREQ-1:0]       GNT,
    output logic                  RSP_VALID,
    output logic [WIDTH-1:0]      RSP_DATA,
    output logic                  RSP_ERR
);

    localparam int c_idx_w   = $clog2(NREQ);
    localparam int c_tries_w = $clog2(MAX_TRIES + 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_idx_w-1:0]     r_idx;
    logic [c_idx_w-1:0]     r_ptr;
    logic [WIDTH-1:0]       r_min;
    logic [WIDTH-1:0]       r_diff;
    logic [WIDTH-1:0]       r_mask;
    logic                   r_range_err;
    logic [c_tries_w-1:0]   r_tries;
    logic [NREQ-1:0]        r_gnt;
    logic                   r_valid;
    logic [WIDTH-1:0]       r_data;
    logic                   r_err;

    logic [4:0]             w_pick;
    logic [c_idx_w-1:0]     w_pick_idx;
    logic [WIDTH-1:0]       w_min_sel;
    logic [WIDTH-1:0]       w_max_sel;
    logic [WIDTH-1:0]       w_diff;
    logic [31:0]            w_mask_full;
    logic [31:0]            w_lfsr;
    logic [WIDTH-1:0]       w_cand;
    logic                   w_accept;
    logic                   w_last_try;
    logic                   w_seed_ld;
    logic [31:0]            w_seed_in;
    logic [NREQ-1:0]        w_gnt_nxt;
    logic                   w_valid_nxt;
    logic [WIDTH-1:0]       w_data_nxt;
    logic                   w_err_nxt;
    logic                   w_unused_bits;

`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
    assign w_seed_ld = SEED_LD;
    assign w_seed_in = SEED_IN;
`else
    assign w_seed_ld = 1'b0;
    assign w_seed_in = 32'h0;
`endif

    assign w_pick      = rr_pick(16'(REQ), 4'(r_ptr), NREQ);
    assign w_pick_idx  = c_idx_w'(w_pick[3:0]);
    assign w_min_sel   = REQ_MIN[int'(w_pick_idx)*WIDTH +: WIDTH];
    assign w_max_sel   = REQ_MAX[int'(w_pick_idx)*WIDTH +: WIDTH];
    assign w_diff      = w_max_sel - w_min_sel;
    assign w_mask_full = mask_of(32'(w_diff));

    // Candidate comes from the state before this cycle's step or load
    assign w_cand     = w_lfsr[WIDTH-1:0] & r_mask;
    assign w_accept   = (w_cand <= r_diff);
    assign w_last_try = (r_tries == c_tries_w'(MAX_TRIES - 1));

    assign w_unused_bits = ^{w_lfsr, w_mask_full};

    cr_lfsr32 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk        (CLK),
        .rst        (RST),
        .i_step     ((r_state == ST_DRAW) && !r_range_err),
        .i_load     (w_seed_ld),
        .i_load_val (w_seed_in),
        .o_state    (w_lfsr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick[4]) w_state_nxt = ST_DRAW;
            end
            ST_DRAW: begin
                if (!REQ[r_idx])
                    w_state_nxt = ST_IDLE;
                else if (r_range_err || w_accept || w_last_try)
                    w_state_nxt = ST_GRANT;
            end
            ST_GRANT: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Response is computed in the final DRAW cycle and registered into GRANT
    always_comb begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_data_nxt  = '0;
        w_err_nxt   = 1'b0;
        if ((r_state == ST_DRAW) && (w_state_nxt == ST_GRANT)) begin
            w_gnt_nxt[r_idx] = 1'b1;
            w_valid_nxt      = 1'b1;
            if (r_range_err || !w_accept) begin
                w_data_nxt = r_min;
                w_err_nxt  = 1'b1;
            end else begin
                w_data_nxt = r_min + w_cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx       <= '0;
            r_ptr       <= '0;
            r_min       <= '0;
            r_diff      <= '0;
            r_mask      <= '0;
            r_range_err <= 1'b0;
            r_tries     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tries <= '0;
                    if (w_pick[4]) begin
                        r_idx       <= w_pick_idx;
                        r_min       <= w_min_sel;
                        r_diff      <= w_diff;
                        r_mask      <= w_mask_full[WIDTH-1:0];
                        r_range_err <= (w_min_sel > w_max_sel);
                    end
                end
                ST_DRAW: begin
                    if (REQ[r_idx] && !r_range_err && !w_accept)
                        r_tries <= r_tries + c_tries_w'(1);
                end
                ST_GRANT: begin
                    r_tries <= '0;
                    r_ptr   <= (r_idx == c_idx_w'(NREQ - 1)) ? '0 : r_idx + c_idx_w'(1);
                end
                default: r_tries <= '0;
            endcase
        end
    end

    assign GNT       = r_gnt;
    assign RSP_VALID = r_valid;
    assign RSP_DATA  = r_data;
    assign RSP_ERR   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_constrained_random_arbiter.sv
// ============================================================================
// Module      : tb_constrained_random_arbiter
// Description : Self-checking bench: fixed vector table, corner sequences and
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_constrained_random_arbiter;

    localparam int MAX_TRIES = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] REQ_MIN, REQ_MAX;
    logic [3:0]  GNT;
    logic        RSP_VALID;
    logic [7:0]  RSP_DATA;
    logic        RSP_ERR;

    logic [3:0]  fb_req;
    logic [31:0] fb_min, fb_max;
    logic [3:0]  fb_gnt;
    logic        fb_valid;
    logic [7:0]  fb_data;
    logic        fb_err;

`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
    logic        SEED_LD, fb_seed_ld;
    logic [31:0] SEED_IN, fb_seed_in;
`endif

    constrained_random_arbiter #(.NREQ(4), .WIDTH(8), .MAX_TRIES(MAX_TRIES), .SEED(32'h1)) dut (
        .CLK(CLK), .RST(RST),
`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
        .SEED_LD(SEED_LD), .SEED_IN(SEED_IN),
`endif
        .REQ(REQ), .REQ_MIN(REQ_MIN), .REQ_MAX(REQ_MAX),
        .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR)
    );

    // Second instance: one try only, seed with low byte 200 to force fallback
    constrained_random_arbiter #(.NREQ(4), .WIDTH(8), .MAX_TRIES(1), .SEED(32'h000000C8)) dut_fb (
        .CLK(CLK), .RST(RST),
`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
        .SEED_LD(fb_seed_ld), .SEED_IN(fb_seed_in),
`endif
        .REQ(fb_req), .REQ_MIN(fb_min), .REQ_MAX(fb_max),
        .GNT(fb_gnt), .RSP_VALID(fb_valid), .RSP_DATA(fb_data), .RSP_ERR(fb_err)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          fails   = 0;
    logic [31:0] m_lfsr;
    int          m_ptr;
    int          hist[256];

    typedef struct {
        int idx; int mn; int mx; int data; int err; int lat;
    } vec_t;
    vec_t tbl[9];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_rng(input int i, input int mn, input int mx);
        REQ_MIN[i*8 +: 8] = 8'(mn);
        REQ_MAX[i*8 +: 8] = 8'(mx);
    endtask

    task automatic rst_all();
        RST = 1'b1;
        REQ = '0;
        fb_req = '0;
        tick();
        tick();
        RST = 1'b0;
        m_lfsr = 32'h1;
        m_ptr  = 0;
    endtask

    // Reference model: spec-level LFSR step, rejection draw and round-robin pick
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic model_draw(input int mn, input int mx, output int data, output bit err,
                              output int cycles);
        int diff, mask, r;
        if (mn > mx) begin
            data = mn; err = 1'b1; cycles = 1;
            return;
        end
        diff = mx - mn;
        mask = 0;
        while (mask < diff) mask = mask * 2 + 1;
        for (int t = 0; t < MAX_TRIES; t++) begin
            r = int'(m_lfsr[7:0]) & mask;
            m_lfsr = lfsr_next(m_lfsr);
            if (r <= diff) begin
                data = mn + r; err = 1'b0; cycles = t + 1;
                return;
            end
        end
        data = mn; err = 1'b1; cycles = MAX_TRIES;
    endtask

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic expect_grant(input int eidx, input int edata, input bit eerr, input int elat,
                                input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (GNT == 4'd0 && n < 64);
        chk({nm, " latency"}, n, elat);
        chk({nm, " gnt"}, int'(GNT), 1 << eidx);
        chk({nm, " valid"}, int'(RSP_VALID), 1);
        chk({nm, " data"}, int'(RSP_DATA), edata);
        chk({nm, " err"}, int'(RSP_ERR), int'(eerr));
    endtask

    task automatic fb_expect(input int edata, input bit eerr, input int elat, input string nm);
        int n = 0;
        do begin
            tick();
            n++;
        end while (fb_gnt == 4'd0 && n < 64);
        chk({nm, " latency"}, n, elat);
        chk({nm, " gnt"}, int'(fb_gnt), 1);
        chk({nm, " data"}, int'(fb_data), edata);
        chk({nm, " err"}, int'(fb_err), int'(eerr));
    endtask

    task automatic model_grant(input int base, input string nm, output int g);
        int  d, cyc;
        bit  e;
        g = model_pick(REQ);
        model_draw(int'(REQ_MIN[g*8 +: 8]), int'(REQ_MAX[g*8 +: 8]), d, e, cyc);
        m_ptr = (g + 1) % 4;
        expect_grant(g, d, e, base + cyc, nm);
    endtask

    task automatic rand_rng(input int i);
        int mn, mx;
        case ($urandom_range(0, 4))
            0: begin mn = $urandom_range(0, 255); mx = mn; end
            1: begin mn = 0; mx = 255; end
            4: begin mn = $urandom_range(0, 200); mx = mn + $urandom_range(0, 20); end
            default: begin mn = $urandom_range(0, 255); mx = $urandom_range(0, 255); end
        endcase
        set_rng(i, mn, mx);
    endtask

    initial begin
        int g;
        // idx, min, max, data, err, latency; LFSR starts at 1 after reset
        tbl[0] = '{0,   5,   5,   5, 0, 2};
        tbl[1] = '{1,   0, 255,   3, 0, 2};
        tbl[2] = '{2,   9,   4,   9, 1, 2};
        tbl[3] = '{3,   3,  10,   5, 0, 2};
        tbl[4] = '{0,   0, 255,   1, 0, 2};
        tbl[5] = '{1, 100, 100, 100, 0, 2};
        tbl[6] = '{2,   0,   1,   0, 0, 2};
        tbl[7] = '{3,  10,  12,  11, 0, 2};
        tbl[8] = '{0,   0,   2,   2, 0, 3};

        REQ = '0; REQ_MIN = '0; REQ_MAX = '0;
        fb_req = '0; fb_min = '0; fb_max = '0;
`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
        SEED_LD = 1'b0; SEED_IN = '0; fb_seed_ld = 1'b0; fb_seed_in = '0;
`endif
        rst_all();
        chk("reset gnt", int'(GNT), 0);
        chk("reset valid", int'(RSP_VALID), 0);
        chk("reset data", int'(RSP_DATA), 0);
        chk("reset err", int'(RSP_ERR), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle gnt", int'(GNT), 0);
        end

        for (int k = 0; k < 9; k++) begin
            REQ = 4'(1 << tbl[k].idx);
            set_rng(tbl[k].idx, tbl[k].mn, tbl[k].mx);
            expect_grant(tbl[k].idx, tbl[k].data, tbl[k].err[0], tbl[k].lat, $sformatf("table%0d", k));
            REQ = '0;
            tick();
        end

        // Fallback: first candidate 200 > 128 with one try, then 100 is accepted
        fb_req = 4'b0001;
        fb_min[7:0] = 8'd0;
        fb_max[7:0] = 8'd128;
        fb_expect(0, 1'b1, 2, "fallback");
        fb_expect(100, 1'b0, 3, "after fallback");
        fb_req = '0;

        // Abort: requester 1 drops in DRAW; pointer stays at 1 so 3 beats 0
        rst_all();
        REQ = 4'b0001; set_rng(0, 1, 1);
        expect_grant(0, 1, 1'b0, 2, "pre-abort");
        REQ = '0;
        tick();
        REQ = 4'b0010; set_rng(1, 50, 50);
        tick();
        REQ = 4'b1001; set_rng(3, 77, 77);
        expect_grant(3, 77, 1'b0, 3, "abort");
        REQ = '0;

        // Reset in DRAW: outputs clear and pointer returns to 0
        rst_all();
        REQ = 4'b0010; set_rng(1, 50, 50);
        expect_grant(1, 50, 1'b0, 2, "pre-reset");
        REQ = '0;
        tick();
        REQ = 4'b0100; set_rng(2, 60, 60);
        tick();
        RST = 1'b1;
        tick();
        chk("rst-draw gnt", int'(GNT), 0);
        chk("rst-draw valid", int'(RSP_VALID), 0);
        chk("rst-draw data", int'(RSP_DATA), 0);
        chk("rst-draw err", int'(RSP_ERR), 0);
        RST = 1'b0;
        REQ = 4'b1001; set_rng(0, 11, 11); set_rng(3, 77, 77);
        expect_grant(0, 11, 1'b0, 2, "rr after reset");
        REQ = '0;

`ifdef CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
        rst_all();
        REQ = 4'b0001; set_rng(0, 0, 255);
        model_grant(1, "pre-load", g);
        REQ = '0;
        tick();
        SEED_IN = 32'h0; SEED_LD = 1'b1;
        tick();
        SEED_LD = 1'b0;
        m_lfsr = 32'h1;
        REQ = 4'b0001;
        model_grant(1, "seed zero load", g);
        REQ = '0;
`endif

        // Single requester 3..10 held for 1000 grants
        rst_all();
        for (int v = 0; v < 256; v++) hist[v] = 0;
        REQ = 4'b0001; set_rng(0, 3, 10);
        for (int k = 0; k < 1000; k++) begin
            model_grant((k == 0) ? 1 : 2, "single", g);
            hist[RSP_DATA]++;
        end
        for (int v = 3; v <= 10; v++) chk($sformatf("hist %0d >= 80", v), int'(hist[v] >= 80), 1);
        REQ = '0;

        // Fairness: all four held, full range
        rst_all();
        for (int i = 0; i < 4; i++) set_rng(i, 0, 255);
        REQ = 4'b1111;
        for (int k = 0; k < 400; k++) begin
            model_grant((k == 0) ? 1 : 2, "fair", g);
            chk("fair order", int'(GNT), 1 << (k % 4));
        end
        REQ = '0;

        // Randomized traffic; only the granted requester may change its request
        rst_all();
        for (int i = 0; i < 4; i++) begin
            rand_rng(i);
            REQ[i] = 1'($urandom_range(0, 1));
        end
        if (REQ == 4'd0) REQ[0] = 1'b1;
        model_grant(1, "rand", g);
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 1) == 0) REQ[g] = 1'b0;
            else rand_rng(g);
            for (int i = 0; i < 4; i++) begin
                if (i != g && !REQ[i] && $urandom_range(0, 2) == 0) begin
                    rand_rng(i);
                    REQ[i] = 1'b1;
                end
            end
            if (REQ == 4'd0) begin
                g = $urandom_range(0, 3);
                rand_rng(g);
                REQ[g] = 1'b1;
            end
            model_grant(2, "rand", g);
        end
        REQ = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/constrained_random_arbiter.md
Name: constrained_random_arbiter

Overview:
Shares one synthesizable pseudo-random source among NREQ requesters. Each requester asks for a value in its own inclusive range [min,max]. A round-robin arbiter selects one request at a time. A small FSM draws from a 32-bit LFSR using rejection sampling, so results are uniform and no modulo is needed, then returns the value with a one-cycle grant pulse. The block sits between testbench or traffic-generator agents and the random source, replacing per-agent random generators.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, value width (1..32)
MAX_TRIES, 8, rejection attempts before fallback (>=1)
SEED, 32'h1, LFSR reset value; 0 is forced to 1

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  reset, synchronous, active-high
REQ  in  NREQ  per-requester request level
REQ_MIN  in  NREQ*WIDTH  packed lower bounds, requester i at [i*WIDTH +: WIDTH]
REQ_MAX  in  NREQ*WIDTH  packed upper bounds, same packing
GNT  out  NREQ  one-hot, one-cycle grant pulse
RSP_VALID  out  1  high with any GNT bit
RSP_DATA  out  WIDTH  result, valid while RSP_VALID
RSP_ERR  out  1  high with RSP_VALID when min>max or fallback was used

Behaviour:
- Reset: synchronous, active-high, from any state including mid-draw. Effects: state=IDLE; GNT=0; RSP_VALID=0; RSP_DATA=0; RSP_ERR=0; rr pointer=0; tries=0; LFSR=SEED (or 1 if SEED==0).
- All outputs are registered.
- States: IDLE, DRAW, GRANT.
- IDLE:
  - If any REQ bit is set, pick the first set bit at or after the rr pointer, wrapping around.
  - Latch idx, min, diff=max-min (WIDTH bits), and mask = smallest 2^k-1 >= diff.
  - Go to DRAW. If no REQ bit is set, stay in IDLE.
- Range error: if latched min>max, skip DRAW and go to GRANT with data=min, err=1.
- DRAW, each cycle:
  - LFSR advances one step: Galois, polynomial x^32+x^22+x^2+x+1.
  - Candidate r = LFSR[WIDTH-1:0] & mask, taken from the pre-advance state.
  - If r<=diff: data=min+r (WIDTH-bit add, no overflow possible), go to GRANT.
  - Else tries++. When tries reaches MAX_TRIES: data=min, err=1, go to GRANT.
  - If REQ[idx] drops during DRAW: abort to IDLE, no grant, rr pointer unchanged.
- GRANT:
  - GNT[idx]=1, RSP_VALID=1, RSP_DATA and RSP_ERR driven for exactly one cycle.
  - rr pointer = (idx+1) mod NREQ; tries=0; return to IDLE.
- Requester rules: hold REQ, REQ_MIN and REQ_MAX stable until the GNT pulse. Holding REQ after GNT requests another value; that requester then competes in the next round at lowest priority.
- Latency: REQ high in cycle c (IDLE) gives GNT in cycle c+2 at minimum and c+1+MAX_TRIES at maximum.
- Back-to-back grants are separated by at least 2 cycles.
- Full range (min=0, max=all ones): mask is all ones and every draw is accepted.
- min==max: mask=0, always accepted, data=min, no LFSR-dependence in the result.
- The LFSR advances only in DRAW, so sequences are reproducible for a given SEED and request order.

Optional Feature:
CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN
- Defined: adds ports SEED_LD (in, 1) and SEED_IN (in, 32).
  - SEED_LD=1 in any state loads LFSR=SEED_IN (0 is forced to 1) on that edge.
  - If the FSM is in DRAW, that cycle's candidate uses the pre-load value; the next cycle uses the loaded seed.
  - RST has priority over SEED_LD.
- Undefined: the ports are absent and the LFSR is reseeded only by RST.

Decomposition:
- Package constrained_random_arb_pkg:
  - FSM state enum (IDLE/DRAW/GRANT)
  - LFSR polynomial constant 32'h80200003
  - mask-of function
  - rr-pick function
- Sub-module cr_lfsr32: holds the 32-bit Galois LFSR; inputs step, load, load value; output state. The arbiter and FSM stay in the top.

Test Plan:
- Reset and idle: RST high 2 cycles, SEED=1, no REQ -> all outputs 0, state IDLE, LFSR==1.
- Single requester, min=3, max=10, REQ[0] held for 1000 grants -> every RSP_DATA in 3..10, RSP_ERR=0, each value hit >=80 times, GNT spacing >=3 cycles.
- Fairness: NREQ=4, all REQ held, all ranges 0..255 -> grant order 0,1,2,3,0,... with no starvation over 400 grants.
- Boundaries:
  - min=max=5 -> data 5, err=0, GNT at c+2.
  - min=0, max=255 (WIDTH=8) -> always accepted at c+2.
  - min=9, max=4 -> data 9, err=1, GNT at c+2.
- Fallback: MAX_TRIES=1, min=0, max=128 with a SEED giving LFSR[7:0]=200 -> data 0, err=1, GNT at c+2.
- Abort and reset mid-draw:
  - Drop REQ[1] in DRAW -> no GNT, next grant goes to the next requester.
  - Assert RST in DRAW -> next cycle IDLE, outputs 0, rr=0.
  - With CONSTRAINED_RANDOM_ARB_SEED_LOAD_EN, SEED_IN=0 -> LFSR=1.
